// File: rtl/vec_lsu_pkg.sv
// Shared types, sizes and element-width helpers for the vector load/store unit.
package vec_lsu_pkg;

    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam int VLW  = $clog2(VLEN / 8) + 1;
    localparam int IDXW = $clog2(VLEN / 8);
    localparam int OFFW = $clog2(VLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    typedef enum logic [2:0] {
        EEW8  = 3'b000,
        EEW16 = 3'b101,
        EEW32 = 3'b110
    } eew_e;

    function automatic logic eew_legal(input logic [2:0] w);
        case (w)
            EEW8, EEW16, EEW32: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] eew_bytes(input logic [2:0] w);
        case (w)
            EEW8:    return 32'd1;
            EEW16:   return 32'd2;
            EEW32:   return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [VLW-1:0] elem_max(input logic [2:0] w);
        case (w)
            EEW8:    return VLW'(VLEN / 8);
            EEW16:   return VLW'(VLEN / 16);
            EEW32:   return VLW'(VLEN / 32);
            default: return VLW'(0);
        endcase
    endfunction

    function automatic logic [ELEN-1:0] elem_mask(input logic [ELEN-1:0] d, input logic [2:0] w);
        case (w)
            EEW8:    return {{(ELEN-8){1'b0}}, d[7:0]};
            EEW16:   return {{(ELEN-16){1'b0}}, d[15:0]};
            EEW32:   return d;
            default: return {ELEN{1'b0}};
        endcase
    endfunction

    function automatic logic [ELEN/8-1:0] strb_of(input logic [2:0] w);
        case (w)
            EEW8:    return 4'b0001;
            EEW16:   return 4'b0011;
            EEW32:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Element address generator: loads base/stride at start, steps by stride per accepted beat.
module vec_lsu_addr_gen
    import vec_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] stride,
    output logic [XLEN-1:0] addr
);

    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] stride_q, stride_d;

    // Next address; the add wraps modulo 2^XLEN by construction.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
        end else if (step) begin
            addr_d = addr_q + stride_q;
        end else begin
            addr_d = addr_q;
        end
    end

    // Address and stride registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/vec_lsu_ldst.sv
// Vector load/store unit: moves one 8/16/32-bit element per accepted memory beat,
// packing loads into vd_data and unpacking vs3_data for stores.
module vec_lsu_ldst
    import vec_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [VLW-1:0]    vl,
    input  logic              stride_sel,
    input  logic              ld_inst,
    input  logic              st_inst,
    input  logic [2:0]        width,
    input  logic [VLEN-1:0]   vs3_data,
    output logic              lsu2mem_req,
    output logic              lsu2mem_we,
    output logic [XLEN-1:0]   lsu2mem_addr,
    output logic [ELEN-1:0]   lsu2mem_wdata,
    output logic [ELEN/8-1:0] lsu2mem_wstrb,
    input  logic              mem2lsu_valid,
    input  logic [ELEN-1:0]   mem2lsu_data,
    output logic [VLEN-1:0]   vd_data,
    output logic              is_loaded,
    output logic              is_stored,
    output logic              busy,
    output logic              lsu_err
);

    lsu_state_e        state_q, state_d;
    logic              is_st_q, is_st_d;
    logic [2:0]        eew_q, eew_d;
    logic [VLW-1:0]    vl_eff_q, vl_eff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [VLEN-1:0]   vs3_q, vs3_d;
    logic [VLEN-1:0]   vd_q, vd_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ELEN-1:0]   wdata_q, wdata_d;
    logic [ELEN/8-1:0] wstrb_q, wstrb_d;
    logic              loaded_q, loaded_d;
    logic              stored_q, stored_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              start_s, legal_s, beat_s, last_s;
    logic              ag_load_s, ag_step_s;
    logic [XLEN-1:0]   ag_stride_s;
    logic [VLW-1:0]    vl_cap_s, vl_lim_s;
    logic [OFFW-1:0]   off8_s, off16_s, off32_s;

    vec_lsu_addr_gen u_addr_gen (
        .clk    (clk),
        .n_rst  (n_rst),
        .load   (ag_load_s),
        .step   (ag_step_s),
        .base   (rs1_data),
        .stride (ag_stride_s),
        .addr   (lsu2mem_addr)
    );

    // FSM, element index, pack/unpack and next values of every registered output.
    always_comb begin
        start_s     = (ld_inst | st_inst) && (state_q == ST_IDLE);
        legal_s     = eew_legal(width) && !(ld_inst && st_inst);
        vl_cap_s    = elem_max(width);
        vl_lim_s    = (vl < vl_cap_s) ? vl : vl_cap_s;
        ag_stride_s = stride_sel ? eew_bytes(width) : rs2_data;
        beat_s      = (state_q == ST_REQ) && mem2lsu_valid;
        last_s      = (({1'b0, idx_q} + {{(VLW-1){1'b0}}, 1'b1}) == vl_eff_q);
        off8_s      = {idx_q, 3'b000};
        off16_s     = {idx_q[IDXW-2:0], 4'b0000};
        off32_s     = {idx_q[IDXW-3:0], 5'b00000};

        state_d   = state_q;
        is_st_d   = is_st_q;
        eew_d     = eew_q;
        vl_eff_d  = vl_eff_q;
        idx_d     = idx_q;
        vs3_d     = vs3_q;
        vd_d      = vd_q;
        err_d     = 1'b0;
        ag_load_s = 1'b0;
        ag_step_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_s && !legal_s) begin
                    err_d = 1'b1;
                end else if (start_s) begin
                    is_st_d   = st_inst;
                    eew_d     = width;
                    vl_eff_d  = vl_lim_s;
                    idx_d     = '0;
                    vs3_d     = vs3_data;
                    ag_load_s = 1'b1;
                    if (ld_inst) begin
                        vd_d = '0;
                    end else begin
                        vd_d = vd_q;
                    end
                    state_d = (vl_lim_s == '0) ? ST_DONE : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (beat_s) begin
                    ag_step_s = 1'b1;
                    // Loads drop the element at idx; stores shift the next element down.
                    case (eew_q)
                        EEW8: begin
                            if (!is_st_q) vd_d[off8_s +: 8] = mem2lsu_data[7:0];
                            else          vd_d = vd_q;
                            vs3_d = vs3_q >> 4'd8;
                        end
                        EEW16: begin
                            if (!is_st_q) vd_d[off16_s +: 16] = mem2lsu_data[15:0];
                            else          vd_d = vd_q;
                            vs3_d = vs3_q >> 5'd16;
                        end
                        EEW32: begin
                            if (!is_st_q) vd_d[off32_s +: 32] = mem2lsu_data;
                            else          vd_d = vd_q;
                            vs3_d = vs3_q >> 6'd32;
                        end
                        default: begin
                            vd_d  = vd_q;
                            vs3_d = vs3_q;
                        end
                    endcase
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_d    = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
        loaded_d = (state_d == ST_DONE) && !is_st_d;
        stored_d = (state_d == ST_DONE) && is_st_d;
        we_d     = req_d && is_st_d;
        if (req_d && is_st_d) begin
            wdata_d = elem_mask(vs3_d[ELEN-1:0], eew_d);
            wstrb_d = strb_of(eew_d);
        end else begin
            wdata_d = '0;
            wstrb_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            is_st_q  <= 1'b0;
            eew_q    <= 3'b000;
            vl_eff_q <= '0;
            idx_q    <= '0;
            vs3_q    <= '0;
            vd_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            loaded_q <= 1'b0;
            stored_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_st_q  <= is_st_d;
            eew_q    <= eew_d;
            vl_eff_q <= vl_eff_d;
            idx_q    <= idx_d;
            vs3_q    <= vs3_d;
            vd_q     <= vd_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            loaded_q <= loaded_d;
            stored_q <= stored_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign lsu2mem_req   = req_q;
    assign lsu2mem_we    = we_q;
    assign lsu2mem_wdata = wdata_q;
    assign lsu2mem_wstrb = wstrb_q;
    assign vd_data       = vd_q;
    assign is_loaded     = loaded_q;
    assign is_stored     = stored_q;
    assign busy          = busy_q;
    assign lsu_err       = err_q;

endmodule

// File: tb/tb_vec_lsu_ldst.sv
// Scoreboard bench for vec_lsu_ldst: expected beats/completions are queued at issue
// and popped by an independent monitor against a byte-addressed memory model.
module tb_vec_lsu_ldst;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [31:0]  rs1_data, rs2_data;
    logic [6:0]   vl;
    logic         stride_sel, ld_inst, st_inst;
    logic [2:0]   width;
    logic [511:0] vs3_data;
    logic         lsu2mem_req, lsu2mem_we;
    logic [31:0]  lsu2mem_addr, lsu2mem_wdata;
    logic [3:0]   lsu2mem_wstrb;
    logic         mem2lsu_valid;
    logic [31:0]  mem2lsu_data;
    logic [511:0] vd_data;
    logic         is_loaded, is_stored, busy, lsu_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct {
        logic [2:0]   kind;   // {err, stored, loaded}
        int           lat;    // 0 = not checked
        logic [511:0] vd;
    } done_t;

    beat_t        exp_beats[$];
    done_t        exp_done[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           beat_cnt = 0;
    bit           stall_en = 1'b0;
    logic [511:0] model_vd = '0;
    logic [511:0] ref_vd;

    vec_lsu_ldst dut (
        .clk(clk), .n_rst(n_rst), .rs1_data(rs1_data), .rs2_data(rs2_data), .vl(vl),
        .stride_sel(stride_sel), .ld_inst(ld_inst), .st_inst(st_inst), .width(width),
        .vs3_data(vs3_data), .lsu2mem_req(lsu2mem_req), .lsu2mem_we(lsu2mem_we),
        .lsu2mem_addr(lsu2mem_addr), .lsu2mem_wdata(lsu2mem_wdata),
        .lsu2mem_wstrb(lsu2mem_wstrb), .mem2lsu_valid(mem2lsu_valid),
        .mem2lsu_data(mem2lsu_data), .vd_data(vd_data), .is_loaded(is_loaded),
        .is_stored(is_stored), .busy(busy), .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] memb(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
    endfunction

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory responder: answers requests just after the clock edge, optionally stalling.
    initial begin
        mem2lsu_valid = 1'b0;
        mem2lsu_data  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem2lsu_valid = lsu2mem_req && (!stall_en || ($urandom_range(0, 3) != 0));
            mem2lsu_data  = lsu2mem_req ? memword(lsu2mem_addr) : 32'd0;
        end
    end

    // Monitor: pops expected beats and completions whenever the DUT presents them.
    initial begin
        bit          held = 1'b0;
        logic [31:0] held_addr = 32'd0;
        beat_t       b;
        done_t       d;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (lsu2mem_req) begin
                    if (held) chk("addr_stable", lsu2mem_addr, held_addr);
                    if (mem2lsu_valid) begin
                        held = 1'b0;
                        beat_cnt++;
                        if (exp_beats.size() == 0) begin
                            chk("unexpected_beat", lsu2mem_req, 1'b0);
                        end else begin
                            b = exp_beats.pop_front();
                            chk("beat_addr", lsu2mem_addr, b.addr);
                            chk("beat_we", lsu2mem_we, b.we);
                            chk("beat_wdata", lsu2mem_wdata, b.wdata);
                            chk("beat_wstrb", lsu2mem_wstrb, b.wstrb);
                            chk("beat_busy", busy, 1'b1);
                        end
                    end else begin
                        held = 1'b1;
                        held_addr = lsu2mem_addr;
                    end
                end else begin
                    held = 1'b0;
                end
                if (is_loaded || is_stored || lsu_err) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", {lsu_err, is_stored, is_loaded}, 3'b000);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_kind", {lsu_err, is_stored, is_loaded}, d.kind);
                        if (d.lat != 0) chk("done_latency", cyc - start_cyc, d.lat);
                        if (d.kind != 3'b100) chk("done_vd", vd_data, d.vd);
                    end
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Queue the expected beats/completion, then pulse the start for one cycle.
    task automatic run_op(input bit is_ld, input bit is_st, input logic [2:0] w,
                          input logic [31:0] rs1, input logic [31:0] rs2, input int vlv,
                          input bit ss, input logic [511:0] vs3, input int exp_lat);
        int           eb, n;
        logic [31:0]  a, stride, mask;
        logic [511:0] vd, tmp;
        beat_t        b;
        done_t        d;
        eb = (w == 3'b000) ? 1 : (w == 3'b101) ? 2 : (w == 3'b110) ? 4 : 0;
        if (eb == 0 || (is_ld && is_st)) begin
            d.kind = 3'b100;
            d.vd   = '0;
        end else begin
            n      = (vlv < 64 / eb) ? vlv : 64 / eb;
            stride = ss ? eb : rs2;
            mask   = (eb == 1) ? 32'h0000_00FF : (eb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            vd     = is_st ? model_vd : '0;
            a      = rs1;
            for (int i = 0; i < n; i++) begin
                b.we = is_st;
                b.addr = a;
                if (is_st) begin
                    tmp = vs3 >> (i * eb * 8);
                    b.wdata = tmp[31:0] & mask;
                    b.wstrb = 4'((1 << eb) - 1);
                end else begin
                    b.wdata = 32'd0;
                    b.wstrb = 4'b0000;
                    for (int k = 0; k < eb; k++) vd[(i * eb + k) * 8 +: 8] = memb(a + k);
                end
                exp_beats.push_back(b);
                a = a + stride;
            end
            if (!is_st) model_vd = vd;
            d.kind = is_st ? 3'b010 : 3'b001;
            d.vd   = vd;
        end
        d.lat = exp_lat;
        exp_done.push_back(d);
        @(negedge clk);
        ld_inst = is_ld; st_inst = is_st; width = w; rs1_data = rs1; rs2_data = rs2;
        vl = 7'(vlv); stride_sel = ss; vs3_data = vs3;
        start_cyc = cyc;
        @(negedge clk);
        ld_inst = 1'b0;
        st_inst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (exp_beats.size() != 0 || exp_done.size() != 0); i++)
            @(negedge clk);
        chk("drain_timeout", exp_beats.size() + exp_done.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [511:0] pat;
        int target;
        n_rst = 1'b0; rs1_data = '0; rs2_data = '0; vl = '0; stride_sel = 1'b0;
        ld_inst = 1'b0; st_inst = 1'b0; width = 3'b000; vs3_data = '0;
        for (int i = 0; i < 16; i++) pat[i * 32 +: 32] = 32'hA000_0000 + 32'(i * 32'h0101_1111);
        repeat (3) @(negedge clk);
        chk("rst_req", lsu2mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vd", vd_data, '0);
        chk("rst_pulses", {is_loaded, is_stored, lsu_err, lsu2mem_we}, 4'b0000);
        chk("rst_addr", lsu2mem_addr, 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1, 0, 3'b110, 32'h200, 32'h0, 16, 1, '0, 17);            drain();
        run_op(1, 0, 3'b000, 32'h400, 32'h3, 64, 0, '0, 65);            drain();
        run_op(0, 1, 3'b101, 32'h100, 32'h0, 5, 1, pat, 6);             drain();
        run_op(1, 0, 3'b110, 32'h300, 32'h0, 0, 1, '0, 1);              drain();
        run_op(1, 0, 3'b110, 32'h800, 32'h0, 20, 1, '0, 17);            drain();
        run_op(1, 0, 3'b111, 32'h200, 32'h0, 4, 1, '0, 1);              drain();
        run_op(1, 1, 3'b000, 32'h200, 32'h0, 4, 1, pat, 1);             drain();
        run_op(0, 1, 3'b110, 32'hFFFF_FFF8, 32'h0, 4, 1, pat, 5);       drain();
        run_op(1, 0, 3'b101, 32'h1000, 32'h6, 40, 0, '0, 33);           drain();

        run_op(1, 0, 3'b110, 32'h200, 32'h0, 16, 1, '0, 17);            drain();
        ref_vd = model_vd;
        stall_en = 1'b1;
        run_op(1, 0, 3'b110, 32'h200, 32'h0, 16, 1, '0, 0);             drain();
        stall_en = 1'b0;
        chk("stall_vd_same", vd_data, ref_vd);

        target = beat_cnt + 3;
        run_op(1, 0, 3'b110, 32'h600, 32'h0, 16, 1, '0, 17);
        for (int i = 0; i < 200 && beat_cnt < target; i++) @(negedge clk);
        chk("beats_before_reset", beat_cnt, target);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_req", lsu2mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_vd", vd_data, '0);
        exp_beats.delete();
        exp_done.delete();
        model_vd = '0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_op(1, 0, 3'b110, 32'h200, 32'h0, 2, 1, '0, 3);              drain();
        chk("final_busy", busy, 1'b0);
        chk("final_req", lsu2mem_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
